// File: rtl/dpram_arbiter.sv
// Round-robin two-port arbiter in front of a dual-port RAM, with same-address hazard
// blocking and per-requester read return. Optional macro: DPRAM_ARB_HAZARD_CNT_EN.
module dpram_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          rvalid,
  output logic [NUM_REQ*DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]           ram_addr_a,
  output logic [ADDR_W-1:0]           ram_addr_b,
  output logic [DATA_W-1:0]           ram_data_a,
  output logic [DATA_W-1:0]           ram_data_b,
  output logic                        ram_rwe_a,
  output logic                        ram_rwe_b,
  input  logic [DATA_W-1:0]           ram_dout_a,
  input  logic [DATA_W-1:0]           ram_dout_b
`ifdef DPRAM_ARB_HAZARD_CNT_EN
  ,
  output logic [15:0]                 hazard_cnt
`endif
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ADDR_W-1:0] addr_u  [NUM_REQ];
  logic [DATA_W-1:0] wdata_u [NUM_REQ];

  logic [IW-1:0] ptr;
  logic [IW-1:0] a_idx;
  logic [IW-1:0] b_idx;
  logic [IW-1:0] last_idx;
  logic [IW-1:0] ptr_nxt;
  logic [IW:0]   s;
  logic          a_hit;
  logic          b_cand;
  logic          hazard;
  logic          gnt_a;
  logic          gnt_b;

  logic          va;
  logic          vb;
  logic [IW-1:0] ia;
  logic [IW-1:0] ib;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_u[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_u[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // Port A searches circularly from ptr; port B from A+1, never revisiting A.
  always_comb begin
    a_hit  = 1'b0;
    a_idx  = '0;
    b_cand = 1'b0;
    b_idx  = '0;
    s      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      if (s >= (IW+1)'(NUM_REQ)) s = s - (IW+1)'(NUM_REQ);
      if (!a_hit && req[s[IW-1:0]]) begin
        a_hit = 1'b1;
        a_idx = s[IW-1:0];
      end
    end
    for (int unsigned k = 0; k + 1 < NUM_REQ; k++) begin
      s = {1'b0, a_idx} + (IW+1)'(k + 1);
      if (s >= (IW+1)'(NUM_REQ)) s = s - (IW+1)'(NUM_REQ);
      if (a_hit && !b_cand && req[s[IW-1:0]]) begin
        b_cand = 1'b1;
        b_idx  = s[IW-1:0];
      end
    end
  end

  // Same address with any write on either side blocks B; two reads may share.
  assign hazard = !rst && b_cand && (addr_u[b_idx] == addr_u[a_idx])
                  && (req_we[a_idx] || req_we[b_idx]);
  assign gnt_a  = a_hit && !rst;
  assign gnt_b  = b_cand && !hazard && !rst;

  assign last_idx = gnt_b ? b_idx : a_idx;
  assign ptr_nxt  = (last_idx == IW'(NUM_REQ - 1)) ? '0 : last_idx + IW'(1);

  always_comb begin
    gnt        = '0;
    ram_addr_a = '0;
    ram_data_a = '0;
    ram_rwe_a  = 1'b0;
    ram_addr_b = '0;
    ram_data_b = '0;
    ram_rwe_b  = 1'b0;
    if (gnt_a) begin
      gnt[a_idx] = 1'b1;
      ram_addr_a = addr_u[a_idx];
      ram_data_a = wdata_u[a_idx];
      ram_rwe_a  = req_we[a_idx];
    end
    if (gnt_b) begin
      gnt[b_idx] = 1'b1;
      ram_addr_b = addr_u[b_idx];
      ram_data_b = wdata_u[b_idx];
      ram_rwe_b  = req_we[b_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      va  <= 1'b0;
      vb  <= 1'b0;
      ia  <= '0;
      ib  <= '0;
    end else begin
      if (gnt_a) ptr <= ptr_nxt;
      va <= gnt_a && !req_we[a_idx];
      vb <= gnt_b && !req_we[b_idx];
      ia <= a_idx;
      ib <= b_idx;
    end
  end

  // Read return lines up with RAM output one cycle after grant; reset drops it.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (!rst) begin
      if (va) begin
        rvalid[ia]                 = 1'b1;
        rdata[ia*DATA_W +: DATA_W] = ram_dout_a;
      end
      if (vb) begin
        rvalid[ib]                 = 1'b1;
        rdata[ib*DATA_W +: DATA_W] = ram_dout_b;
      end
    end
  end

`ifdef DPRAM_ARB_HAZARD_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hazard_cnt <= '0;
    end else if (hazard && hazard_cnt != 16'hFFFF) begin
      hazard_cnt <= hazard_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter: a behavioural 64x8 RAM, gnt/port checks inline,
// read returns checked by a scoreboard monitor.
module tb_dpram_arbiter;

  localparam int N  = 4;
  localparam int AW = 6;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [N*DW-1:0] rdata;
  logic [AW-1:0]   ram_addr_a, ram_addr_b;
  logic [DW-1:0]   ram_data_a, ram_data_b;
  logic            ram_rwe_a, ram_rwe_b;
  logic [DW-1:0]   ram_dout_a, ram_dout_b;
`ifdef DPRAM_ARB_HAZARD_CNT_EN
  logic [15:0]     hazard_cnt;
`endif

  typedef struct {
    int          idx;
    logic [7:0]  data;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dpram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .ram_addr_a (ram_addr_a),
    .ram_addr_b (ram_addr_b),
    .ram_data_a (ram_data_a),
    .ram_data_b (ram_data_b),
    .ram_rwe_a  (ram_rwe_a),
    .ram_rwe_b  (ram_rwe_b),
    .ram_dout_a (ram_dout_a),
    .ram_dout_b (ram_dout_b)
`ifdef DPRAM_ARB_HAZARD_CNT_EN
    ,
    .hazard_cnt (hazard_cnt)
`endif
  );

  // Behavioural RAM: registered read, write at the edge, preloaded with A0+addr.
  logic [7:0] mem [64];
  logic       mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'hA0 + 8'(i);
      mem_init_done <= 1'b1;
    end else begin
      ram_dout_a <= mem[ram_addr_a];
      ram_dout_b <= mem[ram_addr_b];
      if (ram_rwe_a) mem[ram_addr_a] <= ram_data_a;
      if (ram_rwe_b) mem[ram_addr_b] <= ram_data_b;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_rq(input int i, input logic we, input logic [5:0] a, input logic [7:0] d);
    req_we[i]          = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic push_rd(input int i, input logic [7:0] d);
    rd_exp_t e;
    e.idx  = i;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_gnt(input string nm, input logic [3:0] exp);
    #1;
    chk(nm, 32'(gnt), 32'(exp));
  endtask

  task automatic monitor();
    rd_exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rvalid[i] === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rvalid", 32'(i), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("rvalid_idx", 32'(i), 32'(e.idx));
            chk("rdata", 32'(rdata[i*DW +: DW]), 32'(e.data));
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    rst       = 1'b1;
    req       = 4'b1111;
    req_we    = 4'b1111;
    req_addr  = {6'h04, 6'h03, 6'h02, 6'h01};
    req_wdata = {8'h11, 8'h22, 8'h33, 8'h44};
    repeat (3) @(posedge clk);
    #2;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rwe_a", 32'(ram_rwe_a), 32'h0);
    chk("rst_rwe_b", 32'(ram_rwe_b), 32'h0);
    chk("rst_addr_a", 32'(ram_addr_a), 32'h0);
    chk("rst_data_a", 32'(ram_data_a), 32'h0);
    req    = '0;
    req_we = '0;
    rst    = 1'b0;
    #1;
    chk("idle_gnt", 32'(gnt), 32'h0);
    chk("idle_rvalid", 32'(rvalid), 32'h0);
    chk("idle_rwe", {30'h0, ram_rwe_a, ram_rwe_b}, 32'h0);
    chk("idle_ptr", 32'(dut.ptr), 32'h0);
`ifdef DPRAM_ARB_HAZARD_CNT_EN
    chk("idle_hazard_cnt", 32'(hazard_cnt), 32'h0);
`endif
    tick();

    // two writes on both ports in one cycle
    req = 4'b0011;
    set_rq(0, 1'b1, 6'h01, 8'h33);
    set_rq(1, 1'b1, 6'h02, 8'h44);
    chk_gnt("wr2_gnt", 4'b0011);
    chk("wr2_rwe_a", 32'(ram_rwe_a), 32'h1);
    chk("wr2_addr_a", 32'(ram_addr_a), 32'h01);
    chk("wr2_data_a", 32'(ram_data_a), 32'h33);
    chk("wr2_rwe_b", 32'(ram_rwe_b), 32'h1);
    chk("wr2_addr_b", 32'(ram_addr_b), 32'h02);
    chk("wr2_data_b", 32'(ram_data_b), 32'h44);
    tick();
    chk("wr2_ptr", 32'(dut.ptr), 32'h2);

    req = 4'b1100;
    set_rq(2, 1'b0, 6'h01, 8'h00);
    set_rq(3, 1'b0, 6'h02, 8'h00);
    chk_gnt("rd2_gnt", 4'b1100);
    push_rd(2, 8'h33);
    push_rd(3, 8'h44);
    tick();
    chk("rd2_ptr", 32'(dut.ptr), 32'h0);

    // write/read hazard on the same address
    req = 4'b0011;
    set_rq(0, 1'b1, 6'h03, 8'h55);
    set_rq(1, 1'b0, 6'h03, 8'h00);
    chk_gnt("haz_gnt1", 4'b0001);
    tick();
    chk("haz_ptr1", 32'(dut.ptr), 32'h1);
`ifdef DPRAM_ARB_HAZARD_CNT_EN
    chk("hazard_cnt", 32'(hazard_cnt), 32'h1);
`endif
    req = 4'b0010;
    chk_gnt("haz_gnt2", 4'b0010);
    push_rd(1, 8'h55);
    tick();
    chk("haz_ptr2", 32'(dut.ptr), 32'h2);

    req = 4'b1000;
    set_rq(3, 1'b0, 6'h02, 8'h00);
    chk_gnt("align_gnt", 4'b1000);
    push_rd(3, 8'h44);
    tick();
    chk("align_ptr", 32'(dut.ptr), 32'h0);

    // fairness: all four hold reads to distinct addresses
    req = 4'b1111;
    set_rq(0, 1'b0, 6'h01, 8'h00);
    set_rq(1, 1'b0, 6'h02, 8'h00);
    set_rq(2, 1'b0, 6'h03, 8'h00);
    set_rq(3, 1'b0, 6'h00, 8'h00);
    chk_gnt("fair_gnt1", 4'b0011);
    push_rd(0, 8'h33);
    push_rd(1, 8'h44);
    tick();
    chk("fair_ptr1", 32'(dut.ptr), 32'h2);
    chk_gnt("fair_gnt2", 4'b1100);
    push_rd(2, 8'h55);
    push_rd(3, 8'hA0);
    tick();
    chk("fair_ptr2", 32'(dut.ptr), 32'h0);
    chk_gnt("fair_gnt3", 4'b0011);
    push_rd(0, 8'h33);
    push_rd(1, 8'h44);
    tick();
    chk("fair_ptr3", 32'(dut.ptr), 32'h2);

    // two reads of the same address share a cycle
    req = 4'b0101;
    set_rq(0, 1'b0, 6'h01, 8'h00);
    set_rq(2, 1'b0, 6'h01, 8'h00);
    chk_gnt("same_gnt", 4'b0101);
    chk("same_addr_a", 32'(ram_addr_a), 32'h01);
    chk("same_addr_b", 32'(ram_addr_b), 32'h01);
    push_rd(0, 8'h33);
    push_rd(2, 8'h33);
    tick();
    chk("same_ptr", 32'(dut.ptr), 32'h1);

    // pointer wrap from NUM_REQ-1
    req = 4'b0100;
    set_rq(2, 1'b0, 6'h03, 8'h00);
    chk_gnt("wrap_gnt1", 4'b0100);
    push_rd(2, 8'h55);
    tick();
    chk("wrap_ptr1", 32'(dut.ptr), 32'h3);
    req = 4'b1000;
    set_rq(3, 1'b0, 6'h02, 8'h00);
    chk_gnt("wrap_gnt2", 4'b1000);
    push_rd(3, 8'h44);
    tick();
    chk("wrap_ptr2", 32'(dut.ptr), 32'h0);

    // read right after write returns new data
    req = 4'b0010;
    set_rq(1, 1'b1, 6'h05, 8'h66);
    chk_gnt("raw_wr_gnt", 4'b0010);
    tick();
    req = 4'b0100;
    set_rq(2, 1'b0, 6'h05, 8'h00);
    chk_gnt("raw_rd_gnt", 4'b0100);
    push_rd(2, 8'h66);
    tick();
    chk("raw_ptr", 32'(dut.ptr), 32'h3);

    // reset in the cycle after a read grant drops the read
    req = 4'b0001;
    set_rq(0, 1'b0, 6'h01, 8'h00);
    chk_gnt("mid_gnt", 4'b0001);
    tick();
    req = 4'b0000;
    rst = 1'b1;
    #1;
    chk("mid_rvalid_rst", 32'(rvalid), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rvalid_after", 32'(rvalid), 32'h0);
    chk("mid_rdata_after", 32'(rdata), 32'h0);
    chk("mid_ptr", 32'(dut.ptr), 32'h0);
    tick();
    chk("mid_rvalid_after2", 32'(rvalid), 32'h0);

    for (int w = 0; w < 4 && exp_q.size() != 0; w++) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    tick();
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, expected finish before 20000");
    $fatal(1);
  end

endmodule

// File: doc/dpram_arbiter.md
Name: dpram_arbiter

Overview:
- Round-robin arbiter that shares the two ports of the 64x8 dual_port_ram among NUM_REQ requesters, granting up to two requests per cycle (one per port).
- Detects same-address hazards between the two ports and routes each read result back to the requester that issued it.
- Sits directly in front of dual_port_ram; requesters never drive the RAM themselves.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 6, RAM address width
- DATA_W, 8, RAM data width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NUM_REQ  per-requester request, held until granted
- req_we  input  NUM_REQ  1 = write, 0 = read
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  input  NUM_REQ*DATA_W  packed write data
- gnt  output  NUM_REQ  combinational one-hot-per-port grant; the request is accepted at the next rising edge
- rvalid  output  NUM_REQ  read data valid for requester i
- rdata  output  NUM_REQ*DATA_W  packed read data, meaningful only while rvalid[i] is high
- ram_addr_a / ram_addr_b  output  ADDR_W  to RAM addr_a / addr_b
- ram_data_a / ram_data_b  output  DATA_W  to RAM data_a / data_b
- ram_rwe_a / ram_rwe_b  output  1  to RAM RWE_a / RWE_b; 1 = write
- ram_dout_a / ram_dout_b  input  DATA_W  from RAM data_outa / data_outb

Behaviour:
- Reset: clk and rst as above; rst is synchronous, active-high.
  - While rst is high, gnt = 0, ram_rwe_a/b = 0 and ram_addr/data = 0.
  - On the reset edge: ptr = 0, the read-tracking registers are cleared, rvalid = 0 and rdata = 0.
- RAM contract: a write occurs at the clock edge. Read data appears on ram_dout 1 cycle after the address is presented, registered inside the RAM.
- Port A winner: the first i with req[i] set, searching circularly from ptr.
- Port B winner: the first j with req[j] set, searching circularly from A+1 and excluding A.
  - Port B is not granted if addr_j == addr_A and (we_A or we_j); this is a hazard, and j retries next cycle.
  - Two reads to the same address may both be granted.
- Idle port: rwe = 0, addr = 0, data = 0.
- Granted port: drives the winner's addr, wdata and we.
- ptr update at each edge where any grant occurred: ptr <= (last granted index + 1) mod NUM_REQ. The last granted index is B if B was granted, otherwise A. ptr holds when there is no grant.
- Read tracking: registers va/ia and vb/ib hold "port X carried a granted read for requester i".
  - In the following cycle, rvalid[ia] = va and rdata[ia] = ram_dout_a; likewise for port B.
  - Read latency is therefore grant cycle + 1.
  - Writes produce no rvalid.
- Back-to-back operation: a requester may be granted on consecutive cycles. A new grant never disturbs an in-flight rvalid.
- A requester granted on port A and port B can never be the same requester in the same cycle.
- Read after write to the same address in the next cycle returns the new data; the RAM writes at the edge.
- NUM_REQ wrap: the search index wraps modulo NUM_REQ; ptr = NUM_REQ-1 followed by a grant to index NUM_REQ-1 gives ptr = 0.
- Reset mid-operation: an outstanding read is dropped, and no rvalid appears in the cycle after reset.
- No starvation: any held request is granted within NUM_REQ cycles.

Optional Feature:
- Macro: DPRAM_ARB_HAZARD_CNT_EN.
- When defined:
  - Adds output port hazard_cnt, 16 bits.
  - Increments once per cycle in which a port-B candidate was blocked by an address hazard.
  - Saturates at 16'hFFFF and resets to 0.
- When undefined: the port and the counter logic are absent, and arbitration is identical.

Test Plan:
- Reset then idle -> gnt = 0, rvalid = 0, ram_rwe_a = ram_rwe_b = 0, ptr = 0.
- req = 4'b0011, both writes: r0 addr 6'h01 data 8'h33, r1 addr 6'h02 data 8'h44 -> gnt = 0011 in one cycle. Then r2 and r3 read addr 01 and 02 -> rvalid = 1100 one cycle after grant, rdata2 = 8'h33, rdata3 = 8'h44.
- Hazard: r0 writes 8'h55 to 6'h03 while r1 reads 6'h03 at the same time -> cycle 1 gnt = 0001. Cycle 2 gnt = 0010, rvalid[1] in cycle 3 with 8'h55. hazard_cnt = 1 when DPRAM_ARB_HAZARD_CNT_EN is defined.
- Fairness: all four requesters hold read requests to distinct addresses -> grants alternate {0,1}, {2,3}, {0,1}. ptr goes 0 -> 2 -> 0, and each requester is served every 2 cycles.
- Same-address reads: r0 and r2 both read 6'h01 -> both granted in the same cycle, and both get rvalid with 8'h33 in the next cycle.
- Reset mid-read: assert rst in the cycle after a read grant -> no rvalid, and rdata = 0 afterwards.
